muldiv_unit: RTL
================

Name: muldiv_unit

Overview:
Iterative RV32M multiply/divide execution unit that sits directly downstream of the register file. It takes operands read from read_data1/read_data2, computes one M-extension operation over multiple cycles, and returns the result with a write-enable, destination index and data that drive the register file's reg_wr_en, write_reg1 and write_data inputs. The pipeline holds issue while busy is high.

Parameters:
XLEN, 32, operand/result width; the counter width is derived as $clog2(XLEN)+1

Ports:
clock  input  1  system clock, rising edge
resetn  input  1  asynchronous active-low reset
start  input  1  issue request; sampled only in IDLE
funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
op_a  input  XLEN  rs1 value (from read_data1)
op_b  input  XLEN  rs2 value (from read_data2)
rd_in  input  5  destination register index
flush  input  1  abort the in-flight operation
busy  output  1  high whenever state != IDLE
wb_en  output  1  one-cycle write pulse to the register file
wb_reg  output  5  destination index, valid with wb_en
wb_data  output  XLEN  result, valid with wb_en

Behaviour:
- Reset (async, resetn=0): state=IDLE; busy=0, wb_en=0, wb_reg=0, wb_data=0; all internal registers cleared. Reset mid-operation discards the operation and produces no write.
- States: IDLE, CALC, FIX, DONE.
- IDLE, start=1, flush=0: latch funct3, rd_in, operand magnitudes and signs.
  - Operand signedness: MULH and DIV/REM treat both operands as signed. MULHSU treats op_a as signed and op_b as unsigned. MUL, MULHU, DIVU and REMU use unsigned magnitudes; MUL's low word is sign-independent.
  - Load count=XLEN and go to CALC.
  - Special cases go straight to DONE: DIV/DIVU/REM/REMU with op_b=0, and DIV/REM with op_a=0x80000000 and op_b=0xFFFFFFFF.
- CALC: one iteration per cycle; leave when the count reaches 0, then go to FIX.
  - Multiply: radix-2 shift-add into a 2*XLEN accumulator.
  - Divide: restoring shift-subtract into quotient and remainder.
- FIX: one cycle; apply two's-complement sign correction, then go to DONE.
  - Product is negated when sign_a^sign_b.
  - Quotient is negated when sign_a^sign_b.
  - Remainder takes the sign of the dividend.
  - Select the result: MUL = low word; MULH/MULHSU/MULHU = high word; DIV/DIVU = quotient; REM/REMU = remainder.
- DONE: register wb_data and wb_reg; wb_en=1 for exactly this cycle when wb_reg!=0. Return to IDLE.
- Latency, measured from the start-accept edge N:
  - Normal ops: wb_en at cycle N+XLEN+2 (N+34).
  - Special cases: wb_en at N+1.
  - busy is high from N+1 through the DONE cycle inclusive.
  - A new start is accepted in the cycle after DONE.
- Special-case results:
  - Divide by zero: DIV/DIVU = 0xFFFFFFFF; REM/REMU = op_a.
  - Signed overflow: DIV = 0x80000000; REM = 0.
- Handshake rules:
  - start while busy=1 is ignored; no queuing.
  - flush=1 in any state returns to IDLE on the next edge with no wb_en, including flush during DONE.
  - flush and start together in IDLE: flush wins and start is dropped.
- wb_reg and wb_data hold their last values between writes. wb_en is 0 outside DONE.
- Operand inputs are not required to be stable after the accept cycle.

Decomposition:
- Shared package rv32_pkg:
  - XLEN constant.
  - muldiv_op_e enum, 3-bit, holding the funct3 encodings above.
  - muldiv_state_e enum {IDLE, CALC, FIX, DONE}.
- Single flat module. The multiply and divide paths share the accumulator, shifter and adder/subtractor, so no sub-module is needed.

Test Plan:
1. MUL op_a=7, op_b=0xFFFFFFFD (-3), rd_in=5 -> wb_en at N+34, wb_reg=5, wb_data=0xFFFFFFEB; busy high for 34 cycles.
2. High-word products:
   - MULH 0x80000000 x 0x80000000 -> 0x40000000.
   - MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
   - MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
3. Division and remainder:
   - DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD.
   - REM -7 / 2 -> 0xFFFFFFFF.
   - DIVU 100 / 7 -> 14.
   - REMU 100 / 7 -> 2.
4. Special cases:
   - DIV 5 / 0 -> 0xFFFFFFFF at N+1.
   - REMU 5 / 0 -> 5.
   - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 at N+1.
   - REM of the same operands -> 0.
5. Start while busy at N+10 is ignored (only one wb_en). Then:
   - flush at N+5 of a second op -> busy=0 at N+6, no wb_en.
   - flush+start in IDLE -> start dropped.
   - A subsequent MULHU 3 x 5 -> 0.
6. Reset and x0 destination:
   - resetn low mid-CALC -> all outputs 0 immediately, no write after release.
   - MUL 3 x 4 with rd_in=0 -> wb_data=12, wb_en stays 0.

Source files
------------

// File: rtl/rv32_pkg.sv
// rtl/rv32_pkg.sv - shared RV32 constants and M-extension type definitions
package rv32_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } muldiv_state_e;

endpackage

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit with register-file writeback
module muldiv_unit
    import rv32_pkg::*;
#(
    parameter int XLEN = rv32_pkg::XLEN
) (
    input  logic            clock,
    input  logic            resetn,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [4:0]      rd_in,
    input  logic            flush,
    output logic            busy,
    output logic            wb_en,
    output logic [4:0]      wb_reg,
    output logic [XLEN-1:0] wb_data
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = '1;

    muldiv_state_e   state_q, state_d;
    muldiv_op_e      op_q, op_in;
    logic [4:0]      rd_q;
    logic            sign_a_q, sign_b_q;
    logic [XLEN-1:0] mag_x_q;
    logic [2*XLEN-1:0] acc_q;
    logic [CW-1:0]   cnt_q;

    logic            in_sign_a, in_sign_b;
    logic [XLEN-1:0] mag_a_in, mag_b_in;
    logic            is_div_in, div_zero, div_ovf, special;
    logic [XLEN-1:0] special_res;
    logic            accept;

    assign op_in     = muldiv_op_e'(funct3);
    assign is_div_in = funct3[2];
    assign accept    = (state_q == IDLE) && start && !flush;

    always_comb begin
        in_sign_a = 1'b0;
        in_sign_b = 1'b0;
        case (op_in)
            OP_MULH, OP_DIV, OP_REM: begin
                in_sign_a = op_a[XLEN-1];
                in_sign_b = op_b[XLEN-1];
            end
            OP_MULHSU: in_sign_a = op_a[XLEN-1];
            default: ;
        endcase
    end

    assign mag_a_in = in_sign_a ? -op_a : op_a;
    assign mag_b_in = in_sign_b ? -op_b : op_b;

    assign div_zero = is_div_in && (op_b == '0);
    assign div_ovf  = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
                      (op_a == MIN_NEG) && (op_b == ALL_ONES);
    assign special  = div_zero || div_ovf;

    // funct3[1] separates the remainder ops from the quotient ops
    always_comb begin
        special_res = '0;
        if (div_zero)
            special_res = funct3[1] ? op_a : ALL_ONES;
        else
            special_res = funct3[1] ? '0 : MIN_NEG;
    end

    // Shared iteration step: mul shifts right after add, div shifts left then trial-subtracts
    logic [XLEN:0]     mul_sum, div_top, div_diff;
    logic              div_ge;
    logic [2*XLEN-1:0] acc_step;

    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mag_x_q} : '0);
        div_top  = acc_q[2*XLEN-1:XLEN-1];
        div_diff = div_top - {1'b0, mag_x_q};
        div_ge   = ~div_diff[XLEN];
        if (op_q[2])
            acc_step = {(div_ge ? div_diff[XLEN-1:0] : div_top[XLEN-1:0]),
                        acc_q[XLEN-2:0], div_ge};
        else
            acc_step = {mul_sum, acc_q[XLEN-1:1]};
    end

    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem, result;

    always_comb begin
        prod   = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
        quo    = (sign_a_q ^ sign_b_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem    = sign_a_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        result = '0;
        case (op_q)
            OP_MUL:                       result = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: result = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              result = quo;
            OP_REM, OP_REMU:              result = rem;
            default:                      result = '0;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (start) state_d = special ? DONE : CALC;
                CALC: if (cnt_q == CW'(1)) state_d = FIX;
                FIX:  state_d = DONE;
                DONE: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            op_q     <= OP_MUL;
            rd_q     <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            mag_x_q  <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            wb_reg   <= '0;
            wb_data  <= '0;
        end else begin
            if (accept) begin
                op_q     <= op_in;
                rd_q     <= rd_in;
                sign_a_q <= in_sign_a;
                sign_b_q <= in_sign_b;
                cnt_q    <= CW'(XLEN);
                mag_x_q  <= is_div_in ? mag_b_in : mag_a_in;
                acc_q    <= {{XLEN{1'b0}}, (is_div_in ? mag_a_in : mag_b_in)};
                if (special) begin
                    wb_reg  <= rd_in;
                    wb_data <= special_res;
                end
            end else if (state_q == CALC) begin
                acc_q <= acc_step;
                cnt_q <= cnt_q - CW'(1);
            end else if ((state_q == FIX) && !flush) begin
                wb_reg  <= rd_q;
                wb_data <= result;
            end
        end
    end

    assign busy  = (state_q != IDLE);
    assign wb_en = (state_q == DONE) && !flush && (wb_reg != '0);

endmodule
